tpu_seq_ctrl: RTL and testbench

//  Sequencer for the systolic-array TPU core: on tpu_start it runs cfg_num_tiles matrix tiles.

---
 rtl/tpu_seq_ctrl_if.sv | 51 +++++
 rtl/tpu_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_tpu_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_seq_ctrl_if.sv
// tpu_seq_ctrl_if
//   Bundles the command and control signals between a host and the TPU tile
//   sequencer.
//   master : the host side. It drives tpu_start/cfg_num_tiles and observes the rest.
//   slave  : the sequencer side. It receives the start request and drives the
//            SRAM addresses, array strobes, output-bank write enables and status.
//   Signals:
//     tpu_start      one-cycle start request
//     cfg_num_tiles  number of tiles to run
//     sram_raddr_w   weight-bank read address (shared by w0..w7)
//     sram_raddr_d   data-bank read address (shared by d0..d7)
//     w_load_en      array latches a weight row
//     d_valid        array consumes a data row
//     acc_clear      clear of the array accumulators
//     out_shift      array shifts out one result row
//     sram_we_a/b/c  output bank write enables
//     sram_waddr     output bank write address
//     busy           sequencer active
//     tpu_done       completion pulse
interface tpu_seq_ctrl_if #(
  parameter int RADDR_W = 10,
  parameter int WADDR_W = 6,
  parameter int TILE_W  = 8
) ();
  logic               tpu_start;
  logic [TILE_W-1:0]  cfg_num_tiles;
  logic [RADDR_W-1:0] sram_raddr_w;
  logic [RADDR_W-1:0] sram_raddr_d;
  logic               w_load_en;
  logic               d_valid;
  logic               acc_clear;
  logic               out_shift;
  logic               sram_we_a;
  logic               sram_we_b;
  logic               sram_we_c;
  logic [WADDR_W-1:0] sram_waddr;
  logic               busy;
  logic               tpu_done;

  modport master (
    output tpu_start, cfg_num_tiles,
    input  sram_raddr_w, sram_raddr_d, w_load_en, d_valid, acc_clear, out_shift,
    input  sram_we_a, sram_we_b, sram_we_c, sram_waddr, busy, tpu_done
  );

  modport slave (
    input  tpu_start, cfg_num_tiles,
    output sram_raddr_w, sram_raddr_d, w_load_en, d_valid, acc_clear, out_shift,
    output sram_we_a, sram_we_b, sram_we_c, sram_waddr, busy, tpu_done
  );
endinterface

// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl
//   Tile sequencer for the systolic-array TPU core. A start request runs
//   cfg_num_tiles tiles back to back. Each tile has these phases:
//     LOAD_W : 1 entry cycle (acc_clear), then ARRAY_SIZE weight read addresses
//     FEED   : ARRAY_SIZE data read addresses
//     DRAIN  : 2*ARRAY_SIZE-1 quiet cycles while the array pipeline empties
//     WRITE  : ARRAY_SIZE result rows into output bank (tile mod 3)
//   Then one DONE cycle pulses tpu_done.
//   Each tile takes 5*ARRAY_SIZE cycles.
//   Ports:
//     clk    rising-edge clock
//     srstn  synchronous reset, active low
//     bus    tpu_seq_ctrl_if slave modport (start/config in; addresses, strobes
//            and status out)
//   All outputs come straight from flops. The strobes are 0 outside their phase.
//   The addresses hold their last value outside their phase.
module tpu_seq_ctrl #(
  parameter int ARRAY_SIZE = 32,
  parameter int RADDR_W    = 10,
  parameter int WADDR_W    = 6,
  parameter int TILE_W     = 8
) (
  input  logic          clk,
  input  logic          srstn,
  tpu_seq_ctrl_if.slave bus
);

  // cnt must reach 2*ARRAY_SIZE-2 (the last DRAIN cycle)
  localparam int CNT_W = $clog2(2 * ARRAY_SIZE);

  localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(32'd1);
  // LOAD_W runs cnt 0..ARRAY_SIZE: cnt 0 is the acc_clear entry cycle
  localparam logic [CNT_W-1:0]   LOAD_LAST  = CNT_W'(ARRAY_SIZE);
  localparam logic [CNT_W-1:0]   PHASE_LAST = CNT_W'(ARRAY_SIZE - 1);
  localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(2 * ARRAY_SIZE - 2);
  localparam logic [TILE_W-1:0]  TILE_ZERO  = TILE_W'(32'd0);
  localparam logic [TILE_W-1:0]  TILE_ONE   = TILE_W'(32'd1);
  localparam logic [RADDR_W-1:0] RADDR_ZERO = RADDR_W'(32'd0);
  localparam logic [RADDR_W-1:0] RSTEP      = RADDR_W'(ARRAY_SIZE);
  localparam logic [WADDR_W-1:0] WADDR_ZERO = WADDR_W'(32'd0);
  localparam logic [WADDR_W-1:0] WSTEP      = WADDR_W'(ARRAY_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_FEED   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [TILE_W-1:0]  tile_q,   tile_d;
  logic [TILE_W-1:0]  ntiles_q, ntiles_d;
  // rbase = tile*ARRAY_SIZE mod 2^RADDR_W, kept incrementally
  logic [RADDR_W-1:0] rbase_q,  rbase_d;
  // wbase = (tile/3)*ARRAY_SIZE mod 2^WADDR_W; bank = tile mod 3
  logic [WADDR_W-1:0] wbase_q,  wbase_d;
  logic [1:0]         bank_q,   bank_d;
  logic [TILE_W-1:0]  tile_inc;

  logic [RADDR_W-1:0] raddr_w_q,  raddr_w_d;
  logic [RADDR_W-1:0] raddr_d_q,  raddr_d_d;
  logic [WADDR_W-1:0] waddr_q,    waddr_d;
  logic               w_load_en_q, w_load_en_d;
  logic               d_valid_q,   d_valid_d;
  logic               acc_clear_q, acc_clear_d;
  logic               out_shift_q, out_shift_d;
  logic               we_a_q, we_a_d;
  logic               we_b_q, we_b_d;
  logic               we_c_q, we_c_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  assign tile_inc = tile_q + TILE_ONE;

  // State register and tile bookkeeping
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      tile_q   <= TILE_ZERO;
      ntiles_q <= TILE_ZERO;
      rbase_q  <= RADDR_ZERO;
      wbase_q  <= WADDR_ZERO;
      bank_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tile_q   <= tile_d;
      ntiles_q <= ntiles_d;
      rbase_q  <= rbase_d;
      wbase_q  <= wbase_d;
      bank_q   <= bank_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tile_d   = tile_q;
    ntiles_d = ntiles_q;
    rbase_d  = rbase_q;
    wbase_d  = wbase_q;
    bank_d   = bank_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.tpu_start) begin
          ntiles_d = bus.cfg_num_tiles;
          tile_d   = TILE_ZERO;
          rbase_d  = RADDR_ZERO;
          wbase_d  = WADDR_ZERO;
          bank_d   = 2'd0;
          cnt_d    = CNT_ZERO;
          if (bus.cfg_num_tiles == TILE_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD_W;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_FEED;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FEED: begin
        if (cnt_q == PHASE_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_WRITE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WRITE: begin
        if (cnt_q == PHASE_LAST) begin
          cnt_d   = CNT_ZERO;
          tile_d  = tile_inc;
          rbase_d = rbase_q + RSTEP;
          // A full a/b/c rotation moves the write window up by one tile
          if (bank_q == 2'd2) begin
            bank_d  = 2'd0;
            wbase_d = wbase_q + WSTEP;
          end else begin
            bank_d  = bank_q + 2'd1;
            wbase_d = wbase_q;
          end
          if (tile_inc == ntiles_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD_W;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode
  // Addresses and phase strobes are computed from the next state so that,
  // once registered, they line up with state_q. The SRAM-aligned strobes
  // (w_load_en, d_valid) use the current state, which gives them one cycle of
  // lag behind their address.
  always_comb begin
    acc_clear_d = (state_d == ST_LOAD_W) && (cnt_d == CNT_ZERO);
    w_load_en_d = (state_q == ST_LOAD_W) && (cnt_q != CNT_ZERO);
    d_valid_d   = (state_q == ST_FEED);
    out_shift_d = (state_d == ST_WRITE);
    we_a_d      = out_shift_d && (bank_d == 2'd0);
    we_b_d      = out_shift_d && (bank_d == 2'd1);
    we_c_d      = out_shift_d && (bank_d == 2'd2);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
    if ((state_d == ST_LOAD_W) && (cnt_d != CNT_ZERO)) begin
      raddr_w_d = rbase_d + RADDR_W'(cnt_d - CNT_ONE);
    end else begin
      raddr_w_d = raddr_w_q;
    end
    if (state_d == ST_FEED) begin
      raddr_d_d = rbase_d + RADDR_W'(cnt_d);
    end else begin
      raddr_d_d = raddr_d_q;
    end
    if (out_shift_d) begin
      waddr_d = wbase_d + WADDR_W'(cnt_d);
    end else begin
      waddr_d = waddr_q;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!srstn) begin
      raddr_w_q   <= RADDR_ZERO;
      raddr_d_q   <= RADDR_ZERO;
      waddr_q     <= WADDR_ZERO;
      w_load_en_q <= 1'b0;
      d_valid_q   <= 1'b0;
      acc_clear_q <= 1'b0;
      out_shift_q <= 1'b0;
      we_a_q      <= 1'b0;
      we_b_q      <= 1'b0;
      we_c_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      raddr_w_q   <= raddr_w_d;
      raddr_d_q   <= raddr_d_d;
      waddr_q     <= waddr_d;
      w_load_en_q <= w_load_en_d;
      d_valid_q   <= d_valid_d;
      acc_clear_q <= acc_clear_d;
      out_shift_q <= out_shift_d;
      we_a_q      <= we_a_d;
      we_b_q      <= we_b_d;
      we_c_q      <= we_c_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.sram_raddr_w = raddr_w_q;
  assign bus.sram_raddr_d = raddr_d_q;
  assign bus.sram_waddr   = waddr_q;
  assign bus.w_load_en    = w_load_en_q;
  assign bus.d_valid      = d_valid_q;
  assign bus.acc_clear    = acc_clear_q;
  assign bus.out_shift    = out_shift_q;
  assign bus.sram_we_a    = we_a_q;
  assign bus.sram_we_b    = we_b_q;
  assign bus.sram_we_c    = we_c_q;
  assign bus.busy         = busy_q;
  assign bus.tpu_done     = done_q;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Scoreboard bench for tpu_seq_ctrl with ARRAY_SIZE=4, RADDR_W=4.
// Each accepted start pushes the expected strobe events into queues. An event
// is a pair of absolute negedge cycle and value. A negedge monitor pops and
// compares whenever the DUT raises a strobe.
// Timing of a tile t, relative to the start cycle s (start raised after
// negedge s):
//   acc_clear      at s+20t+1
//   w_load_en      at s+20t+3+k, with the previous cycle's raddr_w = 4t+k
//   d_valid        at s+20t+7+k, with the previous cycle's raddr_d = 4t+k
//   write          at s+20t+17+k
//   tpu_done       at s+20N+1
module tb_tpu_seq_ctrl;
  localparam int A  = 4;
  localparam int RW = 4;
  localparam int WW = 6;
  localparam int TW = 8;
  localparam int K_ACC = 0, K_W = 1, K_D = 2, K_WR = 3, K_DONE = 4;

  typedef struct {int cyc; int val;} ev_t;

  logic clk   = 1'b0;
  logic srstn = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   bw_lo = 1;
  int   bw_hi = 0;
  int   prev_rw = 0;
  int   prev_rd = 0;
  ev_t  q_acc[$];
  ev_t  q_w[$];
  ev_t  q_d[$];
  ev_t  q_wr[$];
  ev_t  q_done[$];

  tpu_seq_ctrl_if #(.RADDR_W(RW), .WADDR_W(WW), .TILE_W(TW)) bus ();

  tpu_seq_ctrl #(.ARRAY_SIZE(A), .RADDR_W(RW), .WADDR_W(WW), .TILE_W(TW)) dut (
    .clk   (clk),
    .srstn (srstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    case (kind)
      K_ACC:   q_acc.push_back(e);
      K_W:     q_w.push_back(e);
      K_D:     q_d.push_back(e);
      K_WR:    q_wr.push_back(e);
      default: q_done.push_back(e);
    endcase
  endtask

  task automatic pop_chk(input int kind, input string name, input int obs);
    ev_t e;
    bit  have;
    have = 1'b0;
    case (kind)
      K_ACC:   if (q_acc.size()  > 0) begin e = q_acc.pop_front();  have = 1'b1; end
      K_W:     if (q_w.size()    > 0) begin e = q_w.pop_front();    have = 1'b1; end
      K_D:     if (q_d.size()    > 0) begin e = q_d.pop_front();    have = 1'b1; end
      K_WR:    if (q_wr.size()   > 0) begin e = q_wr.pop_front();   have = 1'b1; end
      default: if (q_done.size() > 0) begin e = q_done.pop_front(); have = 1'b1; end
    endcase
    if (have) begin
      chk({name, " cycle"}, cyc, e.cyc);
      chk({name, " value"}, obs, e.val);
    end else begin
      chk({name, " unexpected event cycle"}, cyc, -1);
    end
  endtask

  // Expected trace for an n-tile run whose start is raised after negedge base
  task automatic push_run(input int n, input int base);
    for (int t = 0; t < n; t++) begin
      int tb;
      tb = base + 20 * t;
      push(K_ACC, tb + 1, 0);
      for (int k = 0; k < A; k++) begin
        push(K_W,  tb + 3 + k,  (4 * t + k) % 16);
        push(K_D,  tb + 7 + k,  (4 * t + k) % 16);
        push(K_WR, tb + 17 + k, 4096 + (t % 3) * 256 + (((t / 3) * 4 + k) % 64));
      end
    end
    push(K_DONE, base + 1 + 20 * n, 0);
    bw_lo = base + 1;
    bw_hi = base + 20 * n;
  endtask

  function automatic int out_vec();
    return int'({bus.sram_raddr_w, bus.sram_raddr_d, bus.sram_waddr, bus.w_load_en,
                 bus.d_valid, bus.acc_clear, bus.out_shift, bus.sram_we_a,
                 bus.sram_we_b, bus.sram_we_c, bus.busy, bus.tpu_done});
  endfunction

  // Monitor: sample every output on the falling edge
  always @(negedge clk) begin
    logic [2:0] we_v;
    int         bank;
    cyc = cyc + 1;
    chk("x_on_outputs", int'($isunknown({bus.sram_raddr_w, bus.sram_raddr_d, bus.sram_waddr,
        bus.w_load_en, bus.d_valid, bus.acc_clear, bus.out_shift, bus.sram_we_a,
        bus.sram_we_b, bus.sram_we_c, bus.busy, bus.tpu_done})), 0);
    chk("busy", int'(bus.busy), ((cyc >= bw_lo) && (cyc <= bw_hi)) ? 1 : 0);
    if (bus.acc_clear) pop_chk(K_ACC, "acc_clear", 0);
    if (bus.w_load_en) pop_chk(K_W, "w_load_en/raddr_w", prev_rw);
    if (bus.d_valid)   pop_chk(K_D, "d_valid/raddr_d", prev_rd);
    we_v = {bus.sram_we_c, bus.sram_we_b, bus.sram_we_a};
    if ((we_v != 3'b000) || bus.out_shift) begin
      case (we_v)
        3'b001:  bank = 0;
        3'b010:  bank = 1;
        3'b100:  bank = 2;
        default: bank = 7;
      endcase
      pop_chk(K_WR, "write shift/bank/waddr", int'(bus.out_shift) * 4096 + bank * 256 + int'(bus.sram_waddr));
    end
    if (bus.tpu_done) pop_chk(K_DONE, "tpu_done", 0);
    prev_rw = int'(bus.sram_raddr_w);
    prev_rd = int'(bus.sram_raddr_d);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int abs_cyc);
    while (cyc < abs_cyc) step();
  endtask

  // Raise start now (just after a negedge), record expectations, drop it next cycle
  task automatic start_run(input int n, output int base);
    bus.cfg_num_tiles = TW'(n);
    bus.tpu_start     = 1'b1;
    base              = cyc;
    push_run(n, base);
    step();
    bus.tpu_start = 1'b0;
  endtask

  task automatic finish_run(input int base, input int n, input string name);
    run_to(base + 20 * n + 4);
    chk({name, " leftover expected events"},
        q_acc.size() + q_w.size() + q_d.size() + q_wr.size() + q_done.size(), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int b2;
    bus.tpu_start     = 1'b0;
    bus.cfg_num_tiles = 8'd0;
    srstn             = 1'b0;
    repeat (3) step();
    chk("reset outputs", out_vec(), 0);
    srstn = 1'b1;
    step();

    // T1: single tile
    step();
    start_run(1, b);
    finish_run(b, 1, "T1");

    // T2: four tiles, bank rotation a,b,c,a
    start_run(4, b);
    finish_run(b, 4, "T2");
    chk("T2 final raddr_w", int'(bus.sram_raddr_w), 15);
    chk("T2 final raddr_d", int'(bus.sram_raddr_d), 15);
    chk("T2 final waddr", int'(bus.sram_waddr), 7);

    // T3: zero tiles -> immediate done, addresses untouched
    start_run(0, b);
    finish_run(b, 0, "T3");
    chk("T3 raddr_w hold", int'(bus.sram_raddr_w), 15);
    chk("T3 raddr_d hold", int'(bus.sram_raddr_d), 15);
    chk("T3 waddr hold", int'(bus.sram_waddr), 7);

    // T4: starts in FEED, WRITE and DONE are ignored; the cycle after DONE is accepted
    start_run(1, b);
    run_to(b + 6);
    bus.tpu_start = 1'b1;
    bus.cfg_num_tiles = 8'd3;
    step();
    bus.tpu_start = 1'b0;
    run_to(b + 17);
    bus.tpu_start = 1'b1;
    step();
    bus.tpu_start = 1'b0;
    run_to(b + 21);
    bus.cfg_num_tiles = 8'd2;
    bus.tpu_start = 1'b1;
    step();
    start_run(1, b2);
    chk("T4 restart cycle after done", b2 - b, 22);
    finish_run(b2, 1, "T4");

    // T5: reset during DRAIN of tile 1 of 3, then a fresh single-tile run
    start_run(3, b);
    run_to(b + 32);
    srstn = 1'b0;
    bw_hi = cyc;
    q_acc.delete();
    q_w.delete();
    q_d.delete();
    q_wr.delete();
    q_done.delete();
    step();
    chk("T5 outputs after mid-run reset", out_vec(), 0);
    srstn = 1'b1;
    step();
    start_run(1, b);
    finish_run(b, 1, "T5");

    // T6: five tiles with a 4-bit read address; tile 4 wraps to 0..3
    start_run(5, b);
    finish_run(b, 5, "T6");
    chk("T6 final raddr_w", int'(bus.sram_raddr_w), 3);
    chk("T6 final waddr", int'(bus.sram_waddr), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
